// File: rtl/rd_job_sequencer_if.sv
// Job-control and read-engine signal bundle for rd_job_sequencer.
// The slave modport is the sequencer's view; master is the job host plus read engine.
interface rd_job_sequencer_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int TMO_WIDTH  = 32
);
  logic                  job_start;
  logic                  job_abort;
  logic [ADDR_WIDTH-1:0] job_base_address;
  logic [31:0]           job_stride;
  logic [15:0]           job_iterations;
  logic                  job_stop_on_error;
  logic [TMO_WIDTH-1:0]  timeout_cycles;
  logic                  rd_done_pulse;
  logic [1:0]            rd_error;
  logic [63:0]           rd_error_info;
  logic                  engine_start_pulse;
  logic [ADDR_WIDTH-1:0] source_address;
  logic                  busy;
  logic                  job_done_pulse;
  logic [1:0]            job_status;
  logic [15:0]           iter_count;
  logic [15:0]           error_count;
  logic [63:0]           first_error_info;

  modport slave (
    input  job_start, job_abort, job_base_address, job_stride, job_iterations,
           job_stop_on_error, timeout_cycles, rd_done_pulse, rd_error, rd_error_info,
    output engine_start_pulse, source_address, busy, job_done_pulse, job_status,
           iter_count, error_count, first_error_info
  );

  modport master (
    output job_start, job_abort, job_base_address, job_stride, job_iterations,
           job_stop_on_error, timeout_cycles, rd_done_pulse, rd_error, rd_error_info,
    input  engine_start_pulse, source_address, busy, job_done_pulse, job_status,
           iter_count, error_count, first_error_info
  );
endinterface

// File: rtl/rd_job_sequencer.sv
// Runs a read engine N times over a strided address range, tracking errors,
// per-iteration timeouts and aborts, and reports one status per job.
module rd_job_sequencer #(
  parameter int ADDR_WIDTH = 64,
  parameter int TMO_WIDTH  = 32
) (
  input logic               clk,
  input logic               rst,
  rd_job_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

  localparam logic [1:0] STATUS_OK    = 2'd0;
  localparam logic [1:0] STATUS_DATA  = 2'd1;
  localparam logic [1:0] STATUS_TMO   = 2'd2;
  localparam logic [1:0] STATUS_ABORT = 2'd3;

  state_t                state_q, state_d;
  logic [15:0]           iterTarget_q, iterTarget_d;
  logic [31:0]           stride_q, stride_d;
  logic                  stopOnErr_q, stopOnErr_d;
  logic [TMO_WIDTH-1:0]  tmoLimit_q, tmoLimit_d;
  logic [TMO_WIDTH-1:0]  timer_q, timer_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           iterCnt_q, iterCnt_d;
  logic [15:0]           errCnt_q, errCnt_d;
  logic [63:0]           firstInfo_q, firstInfo_d;
  logic [1:0]            status_q, status_d;
  logic                  engineStart_q, engineStart_d;
  logic                  jobDone_q, jobDone_d;
  logic                  busy_q, busy_d;
  logic [15:0]           iterNext;
  logic                  errHit;
  logic                  errAny;

  always_comb begin
    state_d      = state_q;
    iterTarget_d = iterTarget_q;
    stride_d     = stride_q;
    stopOnErr_d  = stopOnErr_q;
    tmoLimit_d   = tmoLimit_q;
    timer_d      = timer_q;
    addr_d       = addr_q;
    iterCnt_d    = iterCnt_q;
    errCnt_d     = errCnt_q;
    firstInfo_d  = firstInfo_q;
    status_d     = status_q;
    iterNext     = iterCnt_q + 16'd1;
    errHit       = (bus.rd_error != 2'b00);
    errAny       = errHit || (errCnt_q != 16'd0);

    unique case (state_q)
      IDLE: begin
        if (bus.job_start) begin
          iterTarget_d = bus.job_iterations;
          stride_d     = bus.job_stride;
          stopOnErr_d  = bus.job_stop_on_error;
          tmoLimit_d   = bus.timeout_cycles;
          timer_d      = '0;
          addr_d       = bus.job_base_address;
          iterCnt_d    = '0;
          errCnt_d     = '0;
          firstInfo_d  = '0;
          status_d     = STATUS_OK;
          state_d      = (bus.job_iterations != 16'd0) ? LAUNCH : DONE;
        end
      end
      LAUNCH: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = (&timer_q) ? timer_q : timer_q + TMO_WIDTH'(1);
        // A completion in the same cycle as abort/timeout is always counted first.
        if (bus.rd_done_pulse) begin
          iterCnt_d = iterNext;
          addr_d    = addr_q + ADDR_WIDTH'(stride_q);
          if (errHit) begin
            errCnt_d = (&errCnt_q) ? errCnt_q : errCnt_q + 16'd1;
            if (errCnt_q == 16'd0) firstInfo_d = bus.rd_error_info;
          end
          if ((iterNext == iterTarget_q) || (errHit && stopOnErr_q)) begin
            status_d = errAny ? STATUS_DATA : STATUS_OK;
            state_d  = DONE;
          end else if (bus.job_abort) begin
            status_d = STATUS_ABORT;
            state_d  = DONE;
          end else begin
            state_d = LAUNCH;
          end
        end else if (bus.job_abort) begin
          status_d = STATUS_ABORT;
          state_d  = DONE;
        end else if ((tmoLimit_q != '0) && (timer_q + TMO_WIDTH'(1) == tmoLimit_q)) begin
          status_d = STATUS_TMO;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    engineStart_d = (state_d == LAUNCH);
    jobDone_d     = (state_d == DONE);
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      iterTarget_q  <= '0;
      stride_q      <= '0;
      stopOnErr_q   <= 1'b0;
      tmoLimit_q    <= '0;
      timer_q       <= '0;
      addr_q        <= '0;
      iterCnt_q     <= '0;
      errCnt_q      <= '0;
      firstInfo_q   <= '0;
      status_q      <= '0;
      engineStart_q <= 1'b0;
      jobDone_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      iterTarget_q  <= iterTarget_d;
      stride_q      <= stride_d;
      stopOnErr_q   <= stopOnErr_d;
      tmoLimit_q    <= tmoLimit_d;
      timer_q       <= timer_d;
      addr_q        <= addr_d;
      iterCnt_q     <= iterCnt_d;
      errCnt_q      <= errCnt_d;
      firstInfo_q   <= firstInfo_d;
      status_q      <= status_d;
      engineStart_q <= engineStart_d;
      jobDone_q     <= jobDone_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.engine_start_pulse = engineStart_q;
  assign bus.source_address     = addr_q;
  assign bus.busy               = busy_q;
  assign bus.job_done_pulse     = jobDone_q;
  assign bus.job_status         = status_q;
  assign bus.iter_count         = iterCnt_q;
  assign bus.error_count        = errCnt_q;
  assign bus.first_error_info   = firstInfo_q;
endmodule
